// File: rtl/usb_pkg.sv
// Shared USB buffer-side definitions: packetizer state encoding and widths.
package usb_pkg;

  localparam int USB_BUF_AW     = 9;
  localparam int USB_LEN_W      = 10;
  localparam int USB_MAX_PKT_HS = 512;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    FILL     = 2'd1,
    COMMIT   = 2'd2,
    ACK_LOW  = 2'd3
  } pkt_state_t;

endpackage

// File: rtl/usb_buf_in_packetizer_if.sv
// Stream-side and core-buffer-side signals of the IN packetizer.
// Stream handshake: a byte moves on a rising edge where s_valid && s_ready;
// s_ready never depends on s_valid. Commit handshake: buf_in_commit is a level
// request held with a stable length until buf_in_commit_ack is seen high.
interface usb_buf_in_packetizer_if;
  import usb_pkg::*;

  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [USB_BUF_AW-1:0] buf_in_addr;
  logic [7:0]            buf_in_data;
  logic                  buf_in_wren;
  logic                  buf_in_ready;
  logic                  buf_in_commit;
  logic [USB_LEN_W-1:0]  buf_in_commit_len;
  logic                  buf_in_commit_ack;

  // Packetizer view
  modport slave (
    input  s_data, s_valid, s_last, buf_in_ready, buf_in_commit_ack,
    output s_ready, buf_in_addr, buf_in_data, buf_in_wren,
           buf_in_commit, buf_in_commit_len
  );

  // Environment view: byte source plus USB core buffer
  modport master (
    output s_data, s_valid, s_last, buf_in_ready, buf_in_commit_ack,
    input  s_ready, buf_in_addr, buf_in_data, buf_in_wren,
           buf_in_commit, buf_in_commit_len
  );

endinterface

// File: rtl/usb_idle_timer.sv
// Idle counter with synchronous clear and a terminal-count flag at TIMEOUT-1.
// TIMEOUT=0 keeps the flag low permanently.
module usb_idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt;

  assign tc = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT - 1));

  // Count idle cycles; park at terminal count until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_buf_in_packetizer.sv
// Turns a byte stream into USB IN-buffer writes followed by a length commit.
// Packets close on MAX_PKT bytes, on s_last, or after TIMEOUT idle cycles with
// a partial packet; a full packet ended by s_last is followed by a ZLP when
// ZLP_EN is set. All outputs are registered.
module usb_buf_in_packetizer
  import usb_pkg::*;
#(
  parameter int MAX_PKT = USB_MAX_PKT_HS,
  parameter int TIMEOUT = 1024,
  parameter bit ZLP_EN  = 1'b1
) (
  input  logic                   ext_clk,
  input  logic                   reset,
  usb_buf_in_packetizer_if.slave bus,
  output logic [15:0]            pkt_count,
  output logic                   busy,
  output pkt_state_t             state_dbg
);

  localparam logic [USB_LEN_W-1:0] MAX_LEN = USB_LEN_W'(MAX_PKT);

  pkt_state_t state, state_next;

  logic [USB_LEN_W-1:0]  count, count_d, count_inc;
  logic                  zlp_pending, zlp_d;
  logic                  accept, close_size, ack_seen, timeout_hit;
  logic                  tmr_clr, tmr_tc;

  logic                  s_ready_q, s_ready_d;
  logic                  wren_q, wren_d;
  logic [USB_BUF_AW-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  commit_q, commit_d;
  logic [USB_LEN_W-1:0]  len_q, len_d;
  logic [15:0]           pkt_q, pkt_d;
  logic                  busy_q, busy_d;

  // s_ready_q is high exactly while the FSM sits in FILL
  assign accept      = bus.s_valid && s_ready_q;
  assign count_inc   = count + 1'b1;
  assign close_size  = (count_inc == MAX_LEN);
  // Only an ack seen while our request is up counts as a handshake
  assign ack_seen    = commit_q && bus.buf_in_commit_ack;
  // An accepted byte always beats a coincident timeout
  assign timeout_hit = tmr_tc && (count != '0) && !accept;
  assign tmr_clr     = (state != FILL) || accept || (count == '0);

  usb_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk (ext_clk),
    .rst (reset),
    .clr (tmr_clr),
    .tc  (tmr_tc)
  );

  // State register
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_RDY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision
  always_comb begin
    state_next = state;
    case (state)
      WAIT_RDY: begin
        if (bus.buf_in_ready) begin
          state_next = zlp_pending ? COMMIT : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          if (close_size || bus.s_last) begin
            state_next = COMMIT;
          end
        end else if (timeout_hit) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (ack_seen) begin
          state_next = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!bus.buf_in_commit_ack) begin
          state_next = WAIT_RDY;
        end
      end
      default: state_next = WAIT_RDY;
    endcase
  end

  // Next values of the registered outputs and packet bookkeeping
  always_comb begin
    count_d = count;
    zlp_d   = zlp_pending;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    pkt_d   = pkt_q;

    if ((state == WAIT_RDY) && bus.buf_in_ready && zlp_pending) begin
      zlp_d = 1'b0;
    end

    if (accept) begin
      wren_d  = 1'b1;
      addr_d  = count[USB_BUF_AW-1:0];
      data_d  = bus.s_data;
      count_d = count_inc;
      if (ZLP_EN && bus.s_last && close_size) begin
        zlp_d = 1'b1;
      end
    end

    if (ack_seen) begin
      pkt_d   = pkt_q + 16'd1;
      count_d = '0;
    end

    // Length is captured once, on the transition into COMMIT
    if ((state != COMMIT) && (state_next == COMMIT)) begin
      len_d = count_d;
    end

    s_ready_d = (state_next == FILL);
    // Commit rises one cycle after entering COMMIT, keeping it clear of the last write
    commit_d  = (state == COMMIT) && !ack_seen;
    busy_d    = (state_next != WAIT_RDY);
  end

  // Output and datapath registers
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      zlp_pending <= 1'b0;
      s_ready_q   <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      commit_q    <= 1'b0;
      len_q       <= '0;
      pkt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      count       <= count_d;
      zlp_pending <= zlp_d;
      s_ready_q   <= s_ready_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      len_q       <= len_d;
      pkt_q       <= pkt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.s_ready           = s_ready_q;
  assign bus.buf_in_wren       = wren_q;
  assign bus.buf_in_addr       = addr_q;
  assign bus.buf_in_data       = data_q;
  assign bus.buf_in_commit     = commit_q;
  assign bus.buf_in_commit_len = len_q;
  assign pkt_count             = pkt_q;
  assign busy                  = busy_q;
  assign state_dbg             = state;

endmodule

// File: tb/tb_usb_buf_in_packetizer.sv
// Bench for usb_buf_in_packetizer: directed packets, a byte/packet-level model
// with expected-write and expected-length queues, and a per-cycle compare.
module tb_usb_buf_in_packetizer;
  import usb_pkg::*;

  localparam int MAX_PKT = 512;
  localparam int TIMEOUT = 16;
  localparam bit ZLP_EN  = 1'b1;
  localparam int BOUND   = 2000;

  // ---------------- clock / reset ----------------
  logic ext_clk = 1'b0;
  logic reset   = 1'b1;
  logic [15:0] pkt_count;
  logic        busy;
  pkt_state_t  state_dbg;

  usb_buf_in_packetizer_if bus();

  usb_buf_in_packetizer #(
    .MAX_PKT (MAX_PKT),
    .TIMEOUT (TIMEOUT),
    .ZLP_EN  (ZLP_EN)
  ) dut (
    .ext_clk   (ext_clk),
    .reset     (reset),
    .bus       (bus),
    .pkt_count (pkt_count),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 ext_clk = ~ext_clk;

  int cyc = 0;
  always @(posedge ext_clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [16:0] exp_q[$];   // {addr, data} of each expected buffer write
  logic [9:0]  len_q[$];   // expected commit lengths, in order
  int          model_count = 0;
  int          idle_cnt = 0;
  bit          close_prev = 1'b0;
  bit          commit_prev = 1'b0;
  logic [9:0]  len_prev = '0;
  logic [15:0] exp_pkt = '0;
  int          wren_total = 0;
  int          commit_total = 0;
  int          last_wren_cyc = 0;
  int          commit_rise_cyc = 0;
  logic [16:0] exp_w;
  logic [9:0]  exp_l;

  always @(negedge ext_clk) begin
    if (reset) begin
      check("reset_ctl", 32'({bus.s_ready, bus.buf_in_wren, bus.buf_in_commit, busy}), 0);
      check("reset_pkt", 32'(pkt_count), 0);
      check("reset_len", 32'(bus.buf_in_commit_len), 0);
      check("reset_addr_data", 32'({bus.buf_in_addr, bus.buf_in_data}), 0);
      check("reset_state", 32'(state_dbg), 32'(WAIT_RDY));
      exp_q.delete();
      len_q.delete();
      model_count = 0;
      idle_cnt    = 0;
      close_prev  = 1'b0;
      commit_prev = 1'b0;
      len_prev    = '0;
      exp_pkt     = '0;
    end else begin
      check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
      if (close_prev) check("s_ready_after_close", 32'(bus.s_ready), 0);
      if (bus.buf_in_wren) begin
        wren_total++;
        last_wren_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'(bus.buf_in_wren), 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("wr_addr_data", 32'({bus.buf_in_addr, bus.buf_in_data}), 32'(exp_w));
        end
      end
      if (bus.buf_in_commit) begin
        check("commit_no_wren", 32'(bus.buf_in_wren), 0);
        check("commit_s_ready_low", 32'(bus.s_ready), 0);
        if (!commit_prev) begin
          commit_total++;
          commit_rise_cyc = cyc;
          check("writes_before_commit", 32'(exp_q.size()), 0);
          if (len_q.size() == 0) begin
            check("commit_unexpected", 32'(bus.buf_in_commit), 0);
          end else begin
            exp_l = len_q.pop_front();
            check("commit_len", 32'(bus.buf_in_commit_len), 32'(exp_l));
          end
        end else begin
          check("commit_len_stable", 32'(bus.buf_in_commit_len), 32'(len_prev));
        end
        if (bus.buf_in_commit_ack) exp_pkt = exp_pkt + 16'd1;
      end
      // Packet rules: size, s_last (with ZLP after a full packet), idle timeout
      close_prev = 1'b0;
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back({9'(model_count), bus.s_data});
        model_count++;
        idle_cnt = 0;
        if (model_count == MAX_PKT || bus.s_last) begin
          len_q.push_back(10'(model_count));
          if (ZLP_EN && bus.s_last && model_count == MAX_PKT) len_q.push_back(10'd0);
          model_count = 0;
          close_prev  = 1'b1;
        end
      end else if (bus.s_ready && model_count > 0) begin
        idle_cnt++;
        if (TIMEOUT != 0 && idle_cnt == TIMEOUT) begin
          len_q.push_back(10'(model_count));
          model_count = 0;
          idle_cnt    = 0;
          close_prev  = 1'b1;
        end
      end
      commit_prev = bus.buf_in_commit;
      len_prev    = bus.buf_in_commit_len;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge ext_clk);
    #1;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first, input bit last, input int hold);
    int w;
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = first + 8'(i);
      bus.s_last  = last && (i == n - 1);
      w = 0;
      @(negedge ext_clk);
      while (!bus.s_ready && w < BOUND) begin
        @(negedge ext_clk);
        w++;
      end
      if (!bus.s_ready) begin
        check("send_ready", 32'(bus.s_ready), 1);
        break;
      end
      @(posedge ext_clk);
      #1;
    end
    bus.s_last = 1'b0;
    if (hold > 0) begin
      bus.s_data = 8'hEE;
      tick(hold);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_commit(output logic [9:0] len);
    int w = 0;
    @(negedge ext_clk);
    while (!bus.buf_in_commit && w < 200) begin
      @(negedge ext_clk);
      w++;
    end
    check("commit_seen", 32'(bus.buf_in_commit), 1);
    len = bus.buf_in_commit_len;
  endtask

  task automatic ack_commit(input int hold);
    @(posedge ext_clk);
    #1;
    bus.buf_in_commit_ack = 1'b1;
    tick(hold);
    bus.buf_in_commit_ack = 1'b0;
  endtask

  task automatic do_commit(input int hold, output logic [9:0] len);
    wait_commit(len);
    ack_commit(hold);
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge ext_clk);
    while (!bus.s_ready && w < 10) begin
      @(negedge ext_clk);
      w++;
    end
    check(name, 32'(bus.s_ready), 1);
    @(posedge ext_clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [9:0]  got_len;
  logic [15:0] pk;
  int          base_w, seen, idle, w, c0;

  initial begin
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.buf_in_ready = 1'b0;
    bus.buf_in_commit_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    bus.buf_in_ready = 1'b1;

    // T1: full 512-byte packet, s_valid held, no s_last
    base_w = wren_total;
    send_bytes(512, 8'h00, 1'b0, 3);
    do_commit(1, got_len);
    check("t1_len", 32'(got_len), 512);
    tick(2);
    check("t1_wrens", 32'(wren_total - base_w), 512);
    check("t1_pkt", 32'(pkt_count), 1);

    // T2: 5 bytes closed by s_last, core buffer not ready afterwards
    base_w = wren_total;
    send_bytes(5, 8'hA0, 1'b1, 3);
    bus.buf_in_ready = 1'b0;
    do_commit(1, got_len);
    check("t2_len", 32'(got_len), 5);
    check("t2_commit_gap_ge1", 32'((commit_rise_cyc - last_wren_cyc) >= 1), 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ext_clk);
      if (bus.s_ready) seen++;
    end
    check("t2_s_ready_while_not_rdy", 32'(seen), 0);
    check("t2_idle_busy", 32'(busy), 0);
    check("t2_wrens", 32'(wren_total - base_w), 5);
    check("t2_pkt", 32'(pkt_count), 2);
    bus.buf_in_ready = 1'b1;
    wait_ready("t2_refill");

    // T3: 3 bytes then idle -> forced commit after TIMEOUT idle cycles
    send_bytes(3, 8'h55, 1'b0, 0);
    idle = 0;
    w = 0;
    @(negedge ext_clk);
    while (bus.s_ready && w < 100) begin
      if (!bus.s_valid) idle++;
      w++;
      @(negedge ext_clk);
    end
    check("t3_idle_cycles", 32'(idle), 16);
    do_commit(1, got_len);
    check("t3_len", 32'(got_len), 3);
    tick(2);
    check("t3_pkt", 32'(pkt_count), 3);

    // T4: 512 bytes ending in s_last -> full commit then ZLP
    base_w = wren_total;
    send_bytes(512, 8'h80, 1'b1, 0);
    do_commit(1, got_len);
    check("t4_len", 32'(got_len), 512);
    do_commit(1, got_len);
    check("t4_zlp_len", 32'(got_len), 0);
    tick(2);
    check("t4_wrens", 32'(wren_total - base_w), 512);
    check("t4_pkt", 32'(pkt_count), 5);

    // T5: ack held high for 10 cycles with buffer ready
    send_bytes(4, 8'h11, 1'b1, 0);
    wait_commit(got_len);
    check("t5_len", 32'(got_len), 4);
    pk = pkt_count;
    @(posedge ext_clk);
    #1;
    bus.buf_in_commit_ack = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ext_clk);
      if (bus.s_ready) seen++;
    end
    check("t5_busy_during_ack", 32'(busy), 1);
    @(posedge ext_clk);
    #1;
    bus.buf_in_commit_ack = 1'b0;
    check("t5_no_refill_during_ack", 32'(seen), 0);
    check("t5_pkt_delta", 32'(16'(pkt_count - pk)), 1);
    wait_ready("t5_refill");
    check("t5_pkt", 32'(pkt_count), 6);

    // T6: reset, then idle with nothing to send -> never commits
    #2 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    c0 = commit_total;
    tick(100);
    check("t6_no_commit", 32'(commit_total - c0), 0);
    check("t6_pkt", 32'(pkt_count), 0);
    check("t6_s_ready", 32'(bus.s_ready), 1);

    // T7: reset mid-packet drops wren/commit/s_ready at once
    send_bytes(7, 8'h30, 1'b0, 0);
    check("t7_wren_before", 32'(bus.buf_in_wren), 1);
    #2 reset = 1'b1;
    #1;
    check("t7_wren_async", 32'(bus.buf_in_wren), 0);
    check("t7_commit_async", 32'(bus.buf_in_commit), 0);
    check("t7_s_ready_async", 32'(bus.s_ready), 0);
    tick(3);
    reset = 1'b0;
    wait_ready("t7_refill");
    base_w = wren_total;
    send_bytes(2, 8'hC3, 1'b1, 0);
    do_commit(1, got_len);
    check("t7_len", 32'(got_len), 2);
    tick(2);
    check("t7_wrens", 32'(wren_total - base_w), 2);
    check("t7_pkt", 32'(pkt_count), 1);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=sequence_done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
